number_grid_manager: RTL and testbench

- Parametrised successor to the fixed 12-number display: places a ROWS x COLS grid of digit slots from origin/step parameters.
- Per slot it holds a live digit value, an alive flag and a respawn timer.
- Hits kill the slot under the beam; a killed slot respawns after a frame delay with an LFSR-random digit.
- Sits between the VGA pixel counter and the digit bitmap/RGB mux; reports hit events to the scoring logic.

---
 rtl/number_grid_manager.sv | 171 +++++++++++++++++
 tb/tb_number_grid_manager.sv | 284 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/number_grid_manager.sv
`timescale 1ns/1ps
// number_grid_manager: ROWS x COLS grid of digit slots placed from origin/step
// parameters. Each slot has a live digit, an alive flag and a respawn timer.
// Ports: clk, reset (sync, active-high), startOfFrame, pixelX/pixelY (beam),
//   singleHit (collision with numDR) -> numDR/slotIdx/digit/offsetX/offsetY
//   (1-cycle pixel path), hitValid/hitSlot/hitValue (kill event), aliveMask.
module number_grid_manager #(
    parameter int NUM_COLS       = 4,
    parameter int NUM_ROWS       = 3,
    parameter int ORIGIN_X       = 150,
    parameter int ORIGIN_Y       = 150,
    parameter int STEP_X         = 50,
    parameter int STEP_Y         = 50,
    parameter int DIGIT_W        = 16,
    parameter int DIGIT_H        = 32,
    parameter int RESPAWN_FRAMES = 60,
    parameter logic [15:0] LFSR_SEED = 16'hACE1,
    localparam int N     = NUM_ROWS * NUM_COLS,
    localparam int IDX_W = (N > 1) ? $clog2(N) : 1,
    localparam int OX_W  = (DIGIT_W > 1) ? $clog2(DIGIT_W) : 1,
    localparam int OY_W  = (DIGIT_H > 1) ? $clog2(DIGIT_H) : 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             startOfFrame,
    input  logic [10:0]      pixelX,
    input  logic [10:0]      pixelY,
    input  logic             singleHit,
    output logic             numDR,
    output logic [IDX_W-1:0] slotIdx,
    output logic [3:0]       digit,
    output logic [OX_W-1:0]  offsetX,
    output logic [OY_W-1:0]  offsetY,
    output logic             hitValid,
    output logic [IDX_W-1:0] hitSlot,
    output logic [3:0]       hitValue,
    output logic [N-1:0]     aliveMask
);

    localparam int TW = (RESPAWN_FRAMES > 0) ? $clog2(RESPAWN_FRAMES + 1) : 1;

    function automatic int slot_left(int i);
        return ORIGIN_X + (i % NUM_COLS) * STEP_X;
    endfunction

    function automatic int slot_top(int i);
        return ORIGIN_Y + (i / NUM_COLS) * STEP_Y;
    endfunction

    function automatic logic [15:0] rotr(logic [15:0] v, int s);
        logic [31:0] w;
        w = {v, v} >> s;
        return w[15:0];
    endfunction

    // Fold a 4-bit nibble into 0..9.
    function automatic logic [3:0] to_digit(logic [15:0] v);
        return (v[3:0] >= 4'd10) ? v[3:0] - 4'd10 : v[3:0];
    endfunction

    logic             num_dr_q, num_dr_d;
    logic [IDX_W-1:0] slot_idx_q, slot_idx_d;
    logic [3:0]       digit_q, digit_d;
    logic [OX_W-1:0]  off_x_q, off_x_d;
    logic [OY_W-1:0]  off_y_q, off_y_d;
    logic             hit_valid_q, hit_valid_d;
    logic [IDX_W-1:0] hit_slot_q, hit_slot_d;
    logic [3:0]       hit_value_q, hit_value_d;
    logic [N-1:0]     alive_q, alive_d;
    logic [N-1:0]     vis_q, vis_d;
    logic [N-1:0][3:0]    digits_q, digits_d;
    logic [N-1:0][TW-1:0] timer_q, timer_d;
    logic [15:0]      lfsr_q, lfsr_d;
    logic             hit_ok;

    // Pixel path; descending scan so the lowest overlapping index wins.
    always_comb begin
        int px;
        int py;
        num_dr_d   = 1'b0;
        slot_idx_d = '0;
        digit_d    = '0;
        off_x_d    = '0;
        off_y_d    = '0;
        px = int'(pixelX);
        py = int'(pixelY);
        for (int i = N - 1; i >= 0; i--) begin
            if (vis_q[i] &&
                px >= slot_left(i) && px < slot_left(i) + DIGIT_W &&
                py >= slot_top(i)  && py < slot_top(i) + DIGIT_H) begin
                num_dr_d   = 1'b1;
                slot_idx_d = IDX_W'(i);
                digit_d    = digits_q[i];
                off_x_d    = OX_W'(px - slot_left(i));
                off_y_d    = OY_W'(py - slot_top(i));
            end
        end
    end

    // Hit, respawn and mask update.
    always_comb begin
        hit_ok      = singleHit && num_dr_q && alive_q[slot_idx_q];
        hit_valid_d = hit_ok;
        hit_slot_d  = hit_ok ? slot_idx_q : '0;
        hit_value_d = hit_ok ? digit_q : 4'd0;
        alive_d     = alive_q;
        timer_d     = timer_q;
        digits_d    = digits_q;
        for (int i = 0; i < N; i++) begin
            if (hit_ok && slot_idx_q == IDX_W'(i)) begin
                alive_d[i] = 1'b0;
                timer_d[i] = TW'(RESPAWN_FRAMES);
            end else if (startOfFrame && !alive_q[i]) begin
                if (timer_q[i] == '0) begin
                    alive_d[i]  = 1'b1;
                    digits_d[i] = to_digit(rotr(lfsr_q, i % 16));
                end else begin
                    timer_d[i] = timer_q[i] - TW'(1);
                end
            end
        end
        // Visibility only changes at frame start to avoid tearing.
        vis_d  = startOfFrame ? alive_d : vis_q;
        lfsr_d = {1'b0, lfsr_q[15:1]} ^ (lfsr_q[0] ? 16'hB400 : 16'h0000);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            num_dr_q    <= 1'b0;
            slot_idx_q  <= '0;
            digit_q     <= '0;
            off_x_q     <= '0;
            off_y_q     <= '0;
            hit_valid_q <= 1'b0;
            hit_slot_q  <= '0;
            hit_value_q <= '0;
            alive_q     <= '1;
            vis_q       <= '1;
            timer_q     <= '0;
            lfsr_q      <= LFSR_SEED;
            for (int i = 0; i < N; i++) begin
                digits_q[i] <= 4'(i % 10);
            end
        end else begin
            num_dr_q    <= num_dr_d;
            slot_idx_q  <= slot_idx_d;
            digit_q     <= digit_d;
            off_x_q     <= off_x_d;
            off_y_q     <= off_y_d;
            hit_valid_q <= hit_valid_d;
            hit_slot_q  <= hit_slot_d;
            hit_value_q <= hit_value_d;
            alive_q     <= alive_d;
            vis_q       <= vis_d;
            timer_q     <= timer_d;
            lfsr_q      <= lfsr_d;
            digits_q    <= digits_d;
        end
    end

    assign numDR     = num_dr_q;
    assign slotIdx   = slot_idx_q;
    assign digit     = digit_q;
    assign offsetX   = off_x_q;
    assign offsetY   = off_y_q;
    assign hitValid  = hit_valid_q;
    assign hitSlot   = hit_slot_q;
    assign hitValue  = hit_value_q;
    assign aliveMask = alive_q;

endmodule

// File: tb/tb_number_grid_manager.sv
`timescale 1ns/1ps
// tb_number_grid_manager: directed stimulus with a scoreboard of expected
// outputs; a second instance checks a 2x5 grid with STEP_X=30.
module tb_number_grid_manager;

    localparam int COLS = 4;
    localparam int ROWS = 3;
    localparam int N    = 12;
    localparam int OX0  = 150;
    localparam int OY0  = 150;
    localparam int SX   = 50;
    localparam int SY   = 50;
    localparam int DW   = 16;
    localparam int DH   = 32;
    localparam int RF   = 2;
    localparam logic [15:0] SEED = 16'hACE1;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset = 1'b1;
    logic        sof = 1'b0;
    logic [10:0] px = '0;
    logic [10:0] py = '0;
    logic        hit = 1'b0;
    logic        num_dr;
    logic [3:0]  slot_idx;
    logic [3:0]  digit;
    logic [3:0]  off_x;
    logic [4:0]  off_y;
    logic        hit_valid;
    logic [3:0]  hit_slot;
    logic [3:0]  hit_value;
    logic [11:0] alive;

    logic        g_zero = 1'b0;
    logic [10:0] g_px = '0;
    logic [10:0] g_py = '0;
    logic        g_num_dr;
    logic [3:0]  g_slot;
    logic [3:0]  g_digit;
    logic [3:0]  g_off_x;
    logic [4:0]  g_off_y;
    logic        g_hit_valid;
    logic [3:0]  g_hit_slot;
    logic [3:0]  g_hit_value;
    logic [9:0]  g_alive;

    number_grid_manager #(.RESPAWN_FRAMES(RF)) u_dut (
        .clk(clk), .reset(reset), .startOfFrame(sof),
        .pixelX(px), .pixelY(py), .singleHit(hit),
        .numDR(num_dr), .slotIdx(slot_idx), .digit(digit),
        .offsetX(off_x), .offsetY(off_y),
        .hitValid(hit_valid), .hitSlot(hit_slot), .hitValue(hit_value),
        .aliveMask(alive)
    );

    number_grid_manager #(.NUM_ROWS(2), .NUM_COLS(5), .STEP_X(30)) u_grid (
        .clk(clk), .reset(reset), .startOfFrame(g_zero),
        .pixelX(g_px), .pixelY(g_py), .singleHit(g_zero),
        .numDR(g_num_dr), .slotIdx(g_slot), .digit(g_digit),
        .offsetX(g_off_x), .offsetY(g_off_y),
        .hitValid(g_hit_valid), .hitSlot(g_hit_slot),
        .hitValue(g_hit_value), .aliveMask(g_alive)
    );

    typedef struct {
        bit          dr;
        int          idx;
        int          dig;
        int          ox;
        int          oy;
        bit          hv;
        int          hs;
        int          hval;
        logic [11:0] alv;
    } exp_t;

    exp_t        sb[$];
    exp_t        m_last;
    logic [11:0] m_alive;
    logic [11:0] m_vis;
    int          m_dig[N];
    int          m_tmr[N];
    logic [15:0] m_lfsr;
    int          n_tests = 0;
    int          n_fail = 0;

    task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    function automatic exp_t pix_model(int x, int y);
        exp_t e;
        e = '{default: 0};
        for (int i = 0; i < N; i++) begin
            int l;
            int t;
            l = OX0 + (i % COLS) * SX;
            t = OY0 + (i / COLS) * SY;
            if (!e.dr && m_vis[i] && x >= l && x < l + DW &&
                y >= t && y < t + DH) begin
                e.dr  = 1'b1;
                e.idx = i;
                e.dig = m_dig[i];
                e.ox  = x - l;
                e.oy  = y - t;
            end
        end
        return e;
    endfunction

    function automatic int map_digit(logic [15:0] v, int k);
        logic [15:0] r;
        int d;
        r = (k == 0) ? v : ((v >> k) | (v << (16 - k)));
        d = int'(r[3:0]);
        return (d >= 10) ? d - 10 : d;
    endfunction

    function automatic logic [15:0] lfsr_next(logic [15:0] v);
        logic out;
        logic [15:0] r;
        out = v[0];
        r = v >> 1;
        if (out) r = r ^ 16'hB400;
        return r;
    endfunction

    task automatic check_out();
        exp_t e;
        e = sb.pop_front();
        chk("numDR", 32'(num_dr), 32'(e.dr));
        chk("slotIdx", 32'(slot_idx), e.idx);
        chk("digit", 32'(digit), e.dig);
        chk("offsetX", 32'(off_x), e.ox);
        chk("offsetY", 32'(off_y), e.oy);
        chk("hitValid", 32'(hit_valid), 32'(e.hv));
        chk("aliveMask", 32'(alive), 32'(e.alv));
        if (e.hv) begin
            chk("hitSlot", 32'(hit_slot), e.hs);
            chk("hitValue", 32'(hit_value), e.hval);
        end
    endtask

    task automatic step(int x, int y, bit h, bit s, bit r);
        exp_t e;
        bit hok;
        reset = r;
        px = 11'(x);
        py = 11'(y);
        hit = h;
        sof = s;
        if (r) begin
            e = '{default: 0};
            e.alv = '1;
            m_alive = '1;
            m_vis = '1;
            for (int i = 0; i < N; i++) begin
                m_dig[i] = i % 10;
                m_tmr[i] = 0;
            end
            m_lfsr = SEED;
        end else begin
            e = pix_model(x, y);
            hok = h && m_last.dr && m_alive[m_last.idx];
            e.hv = hok;
            e.hs = m_last.idx;
            e.hval = m_last.dig;
            for (int i = 0; i < N; i++) begin
                if (hok && i == m_last.idx) begin
                    m_alive[i] = 1'b0;
                    m_tmr[i] = RF;
                end else if (s && !m_alive[i]) begin
                    if (m_tmr[i] == 0) begin
                        m_alive[i] = 1'b1;
                        m_dig[i] = map_digit(m_lfsr, i % 16);
                    end else begin
                        m_tmr[i] = m_tmr[i] - 1;
                    end
                end
            end
            if (s) m_vis = m_alive;
            e.alv = m_alive;
            m_lfsr = lfsr_next(m_lfsr);
        end
        m_last = e;
        sb.push_back(e);
        @(posedge clk);
        #1;
        check_out();
    endtask

    task automatic gcheck(int x, int y, bit dr, int idx, int dig,
                          int ox, int oy);
        g_px = 11'(x);
        g_py = 11'(y);
        @(posedge clk);
        #1;
        chk("g_numDR", 32'(g_num_dr), 32'(dr));
        chk("g_slotIdx", 32'(g_slot), idx);
        chk("g_digit", 32'(g_digit), dig);
        chk("g_offsetX", 32'(g_off_x), ox);
        chk("g_offsetY", 32'(g_off_y), oy);
    endtask

    initial begin
        int ys[16] = '{0, 149, 150, 165, 181, 182, 199, 200,
                       219, 231, 232, 249, 250, 281, 282, 524};
        int xs[12] = '{149, 150, 165, 166, 199, 200,
                       215, 216, 249, 250, 265, 266};

        step(0, 0, 0, 0, 1);
        step(0, 0, 0, 0, 1);

        foreach (ys[k]) for (int x = 140; x < 280; x++) step(x, ys[k], 0, 0, 0);
        foreach (xs[k]) for (int y = 140; y < 291; y++) step(xs[k], y, 0, 0, 0);

        step(200, 200, 0, 0, 0);
        chk("corner_idx5", 32'(slot_idx), 5);
        chk("corner_dig5", 32'(digit), 5);
        step(207, 219, 0, 0, 0);
        chk("p207_ox", 32'(off_x), 7);
        chk("p207_oy", 32'(off_y), 19);

        // Kill slot 5, then a second hit on it while still drawn.
        step(0, 0, 1, 0, 0);
        chk("kill5_hv", 32'(hit_valid), 1);
        step(205, 205, 0, 0, 0);
        chk("dead5_drawn", 32'(num_dr), 1);
        step(0, 0, 1, 0, 0);
        step(0, 0, 1, 0, 0);
        step(0, 0, 0, 1, 0);
        step(205, 205, 0, 0, 0);
        chk("dead5_gone", 32'(num_dr), 0);

        // Kill slots 0 and 1 in the same frame, then respawn.
        step(150, 150, 0, 0, 0);
        step(0, 0, 1, 0, 0);
        step(200, 150, 0, 0, 0);
        step(0, 0, 1, 0, 0);
        for (int f = 0; f < 3; f++) begin
            step(0, 0, 0, 1, 0);
            step(150, 150, 0, 0, 0);
            step(200, 150, 0, 0, 0);
        end
        chk("respawn_alive0", 32'(alive[0]), 1);
        chk("respawn_range", 32'(digit < 4'd10), 1);

        // Simultaneous hit and frame start on slot 3.
        step(300, 150, 0, 0, 0);
        step(0, 0, 1, 1, 0);
        chk("hit_sof_hv", 32'(hit_valid), 1);
        step(300, 150, 0, 0, 0);
        chk("hit_sof_gone", 32'(num_dr), 0);

        // Hit while not on a slot.
        step(0, 0, 1, 0, 0);

        // Reset during a valid hit.
        step(250, 150, 0, 0, 0);
        step(0, 0, 1, 0, 1);
        chk("rst_hit_hv", 32'(hit_valid), 0);
        chk("rst_alive", 32'(alive), 32'hFFF);
        step(0, 0, 0, 0, 0);

        gcheck(270, 200, 1, 9, 9, 0, 0);
        gcheck(269, 200, 0, 0, 0, 0, 0);
        gcheck(285, 231, 1, 9, 9, 15, 31);
        gcheck(286, 231, 0, 0, 0, 0, 0);
        gcheck(270, 150, 1, 4, 4, 0, 0);
        gcheck(150, 200, 1, 5, 5, 0, 0);
        chk("g_alive", 32'(g_alive), 32'h3FF);
        chk("g_hitValid", 32'(g_hit_valid), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
